riscv_fetch_unit: RTL

Parametrised instruction-fetch front end for the pipelined core. It generalises the single-cycle PC / PC+4 / branch-target / PC-mux path to configurable XLEN. It adds a valid/ready instruction-memory handshake, an in-order instruction queue of configurable depth, decode backpressure, and branch redirect with squash of in-flight fetches. It sits between instruction memory and the IF/ID boundary.

---
 rtl/riscv_fetch_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch front end: PC generation, credit-based imem request
// stream, in-order instruction queue and branch redirect with squash of
// responses still in flight.
module riscv_fetch_unit #(
    parameter int unsigned     XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter int unsigned     QDEPTH       = 4,
    parameter int unsigned     BRANCH_SHIFT = 1,
    localparam int unsigned    CW           = $clog2(QDEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_base,
    input  logic [XLEN-1:0] redirect_imm,
    output logic            inst_valid,
    output logic [31:0]     inst_data,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready,
    output logic [XLEN-1:0] fetch_pc,
    output logic [CW-1:0]   q_count,
    output logic            fetch_misalign
);

    localparam int unsigned AW   = $clog2(QDEPTH);
    localparam logic [CW:0] QMAX = (CW + 1)'(QDEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic            misalign_q, misalign_d;

    logic [31:0]     q_data [QDEPTH];
    logic [XLEN-1:0] q_pc   [QDEPTH];

    logic [XLEN-1:0] target;
    logic [CW:0]     pending;
    logic            req_fire;
    logic            rsp_push;
    logic            pop;

    // Handshake decode, credit check and redirect target.
    always_comb begin
        target   = redirect_base + (redirect_imm << BRANCH_SHIFT);
        // Entries already queued plus responses that will still be pushed.
        pending  = {1'b0, count_q} + {1'b0, inflight_q} - {1'b0, drop_q};
        // Gated by reset so no request is presented while reset is held.
        imem_req_valid = reset && !misalign_q && !redirect_valid && (pending < QMAX);
        imem_req_addr  = fetch_pc_q;
        inst_valid     = (count_q != '0) && !redirect_valid;
        inst_data      = q_data[rd_ptr_q];
        inst_pc        = q_pc[rd_ptr_q];
        fetch_pc       = fetch_pc_q;
        q_count        = count_q;
        fetch_misalign = misalign_q;
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_push       = imem_rsp_valid && !redirect_valid && (drop_q == '0);
        pop            = inst_valid && inst_ready;
    end

    // Next-state for PCs, counters and queue pointers.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        misalign_d = misalign_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
        drop_d     = drop_q;

        if (redirect_valid) begin
            fetch_pc_d = target;
            resp_pc_d  = target;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            misalign_d = (target[1:0] != 2'b00);
            // Everything still outstanding after this cycle belongs to the old stream.
            drop_d     = inflight_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (imem_rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            if (rsp_push) begin
                resp_pc_d = resp_pc_q + XLEN'(4);
                wr_ptr_d  = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(rsp_push) - CW'(pop);
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            misalign_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            misalign_q <= misalign_d;
        end
    end

    // Queue storage; contents are don't-care whenever count_q is zero.
    always_ff @(posedge clk) begin
        if (rsp_push) begin
            q_data[wr_ptr_q] <= imem_rsp_data;
            q_pc[wr_ptr_q]   <= resp_pc_q;
        end
    end

endmodule
